// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the shared 6-digit segment path.
// Each grant is preceded by blank cycles, so one frame never mixes data from
// two owners. A continuously requesting owner keeps the display for at least
// HoldCycles cycles before a competing requester can take it.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no owner, outputs zero, waiting for any request
//   ST_BLANK | pending owner latched, outputs held at zero for BlankCycles
//   ST_OWN   | owner's segment bytes and digit mask forwarded, registered
module seg_display_arbiter #(
    parameter int NReq        = 3,
    parameter int HoldCycles  = 5000000,
    parameter int BlankCycles = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NReq-1:0]     req_i,
    input  logic [NReq*48-1:0]  seg_i,
    input  logic [NReq*6-1:0]   valid_i,
    output logic [NReq-1:0]     grant_o,
    output logic [47:0]         seg_o,
    output logic [5:0]          valid_o,
    output logic                busy_o
);

    localparam int IDX_W   = $clog2(NReq);
    localparam int HOLD_W  = $clog2(HoldCycles + 1);
    localparam int BLANK_W = $clog2(BlankCycles + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_OWN} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [BLANK_W-1:0] r_blank;
    logic [HOLD_W-1:0]  r_hold;
    logic [NReq-1:0]    r_grant;
    logic [47:0]        r_seg;
    logic [5:0]         r_valid;

    state_t             w_next_state;
    logic [IDX_W-1:0]   w_next_owner;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [BLANK_W-1:0] w_next_blank;
    logic [HOLD_W-1:0]  w_next_hold;
    logic [NReq-1:0]    w_grant_next;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic               w_excl;
    logic               w_hold_done;
    logic               w_blank_last;
    logic [IDX_W-1:0]   w_owner_inc;

    // The current owner is excluded from the search only while it owns the display.
    assign w_excl       = (r_state == ST_OWN);
    // The current OWN cycle is the HoldCycles-th one (counter starts at 0 on entry).
    assign w_hold_done  = (r_hold >= HOLD_W'(HoldCycles - 1));
    assign w_blank_last = (r_blank == BLANK_W'(BlankCycles - 1));
    assign w_owner_inc  = (r_owner == IDX_W'(NReq - 1)) ? '0 : r_owner + 1'b1;

    // Round-robin search from r_ptr, wrapping modulo NReq; first active requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NReq; k++) begin
            int j;
            j = int'(r_ptr) + k;
            if (j >= NReq) j = j - NReq;
            if (!w_found && req_i[j] && !(w_excl && (j == int'(r_owner)))) begin
                w_found = 1'b1;
                w_win   = IDX_W'(j);
            end
        end
    end

    // Next-state logic; an owner dropping its request wins over rotation.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_ptr   = r_ptr;
        w_next_blank = r_blank;
        w_next_hold  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_BLANK;
                    w_next_owner = w_win;
                    w_next_blank = '0;
                end
            end
            ST_BLANK: begin
                if (w_blank_last) begin
                    if (req_i[r_owner]) begin
                        w_next_state = ST_OWN;
                        w_next_hold  = '0;
                        w_next_ptr   = w_owner_inc;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_blank = r_blank + 1'b1;
                end
            end
            ST_OWN: begin
                if (!req_i[r_owner]) begin
                    w_next_state = ST_IDLE;
                end else if (w_hold_done && w_found) begin
                    w_next_state = ST_BLANK;
                    w_next_owner = w_win;
                    w_next_blank = '0;
                end else if (r_hold != HOLD_W'(HoldCycles)) begin
                    w_next_hold = r_hold + 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // One-hot grant for the owner the arbiter will be in OWN with next cycle.
    always_comb begin
        w_grant_next = '0;
        if (w_next_state == ST_OWN) w_grant_next[w_next_owner] = 1'b1;
    end

    // State and output registers; outputs are zero outside OWN so no non-owner data leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_blank <= '0;
            r_hold  <= '0;
            r_grant <= '0;
            r_seg   <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_ptr   <= w_next_ptr;
            r_blank <= w_next_blank;
            r_hold  <= w_next_hold;
            r_grant <= w_grant_next;
            if (w_next_state == ST_OWN) begin
                r_seg   <= seg_i[int'(w_next_owner)*48 +: 48];
                r_valid <= valid_i[int'(w_next_owner)*6 +: 6];
            end else begin
                r_seg   <= '0;
                r_valid <= '0;
            end
        end
    end

    assign grant_o = r_grant;
    assign seg_o   = r_seg;
    assign valid_o = r_valid;
    assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the single 6-digit seven-segment display path (decoded segment bytes plus per-digit enable mask feeding the segment scan driver) between several requesters, such as the key counter and status or message sources. It grants the display to one requester at a time in round-robin order and guarantees each owner a minimum visible hold time. It inserts blank cycles between owners so no mixed-owner frame is ever driven. It sits between the per-digit decoders of each source and the scan driver.

## Interface
- NReq, 3, number of requesters (2..8)
- HoldCycles, 5000000, minimum OWN cycles per grant while the owner keeps requesting (>=1)
- BlankCycles, 16, blank cycles inserted before every grant (>=1)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_i  input  NReq  per-requester display request, level, held while the requester wants the display
- seg_i  input  NReq*48  requester r segment bytes at [r*48 +: 48]; digit d at [d*8 +: 8], active-high segments
- valid_i  input  NReq*6  requester r digit-enable mask at [r*6 +: 6], active-high
- grant_o  output  NReq  one-hot current owner; all zero when no owner
- seg_o  output  48  segment bytes to the scan driver
- valid_o  output  6  digit-enable mask to the scan driver
- busy_o  output  1  high when state is not IDLE

## Operation
- States: IDLE, BLANK, OWN. Registers: state, owner index, round-robin pointer ptr, blank counter, hold counter (saturating at HoldCycles, width clog2(HoldCycles+1)).
- Round-robin search starts at ptr and wraps modulo NReq. The first requester with req_i high wins. On entering OWN for requester r, ptr <= (r+1) mod NReq.
- IDLE:
  - Any req_i high: latch winner as pending owner, go to BLANK, blank counter <= 0.
  - grant_o, seg_o, valid_o all zero.
- BLANK:
  - Lasts exactly BlankCycles cycles. Outputs zero.
  - On the last cycle, if the pending owner's req_i is still high, go to OWN. Otherwise go to IDLE; ptr is unchanged.
  - Requests from others during BLANK are ignored.
- OWN:
  - grant_o = one-hot owner. seg_o/valid_o = owner's seg_i/valid_i slice, registered.
  - Hold counter <= 0 on entry, increments each OWN cycle.
  - Owner req_i low: go to IDLE next cycle regardless of the hold counter.
  - Hold counter has reached HoldCycles and another requester is high: search from ptr (owner excluded), latch the next owner, go to BLANK.
  - Otherwise stay in OWN indefinitely.
- Owner drop and the rotation condition in the same cycle: drop wins, go to IDLE.
- grant_o is never multi-hot. seg_o and valid_o are never driven from a non-owner.

## Timing
- Reset (rst sampled high): next cycle state=IDLE, ptr=0, grant_o=0, seg_o=0, valid_o=0, busy_o=0.
  - Reset overrides every state, including mid-OWN and mid-BLANK.
  - Requests are ignored while rst is high.
- grant_o, seg_o, valid_o and busy_o are all registered and change on the same edge.
- Request sampled at an IDLE edge:
  - BLANK occupies the next BlankCycles cycles.
  - The grant appears in cycle BlankCycles+1 after the sampling cycle.
- During OWN, seg_o/valid_o reflect the owner's inputs from the previous cycle (1-cycle latency).
- With a competing request present, a continuously requesting owner holds the grant for exactly HoldCycles cycles. It is followed by BlankCycles zero cycles, then the next owner.
- Owner release: grant_o and outputs go to zero 1 cycle after req_i is sampled low.

## Test plan
Configuration for all scenarios: NReq=3, HoldCycles=4, BlankCycles=2.

- **Reset:** rst high 2 cycles with req_i=3'b111 -> grant_o=0, seg_o=0, valid_o=0, busy_o=0 throughout. Release rst with req_i=3'b001 -> busy_o high next cycle, 2 zero cycles, then grant_o=3'b001.
- **Priority:** from reset, req_i=3'b110 asserted in the same cycle -> grant_o=3'b010 first (ptr=0, requester 0 idle).
- **Rotation:** req_i=3'b111 held, seg_i slices set to distinct patterns.
  - Grant sequence is 001, 010, 100, 001.
  - Each grant lasts exactly 4 cycles, separated by 2 cycles of grant_o=0, seg_o=0, valid_o=0.
  - seg_o always equals the granted slice.
- **Early release and blank-drop:**
  - Owner 0 drops req in its 2nd OWN cycle -> next cycle IDLE, grant_o=0, hold ignored.
  - Requester 1 asserts and drops during BLANK -> returns to IDLE, never granted, ptr unchanged.
- **Lone owner:**
  - Only req_i[2] high for 50 cycles -> grant_o=3'b100 throughout, with no rotation.
  - Change seg_i[2*48 +: 48] from 48'h3F06_5B4F_666D to 48'h7D07_7F6F_3F06 -> seg_o follows 1 cycle later.
  - valid_i mask 6'b000111 is passed to valid_o unchanged.
- **Reset mid-operation:** assert rst in the 3rd OWN cycle of requester 1 -> next cycle all outputs 0 and ptr=0. With req_i=3'b111 after release, the first grant is 3'b001.
